// File: rtl/bsn_mac_sequencer_pkg.sv
// Shared definitions for the bit-serial MAC sequencer: FSM state codes,
// precision encodings and the period-per-precision lookup.
package bsn_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_RUN   = 3'd1;
   localparam state_t ST_FLUSH = 3'd2;
   localparam state_t ST_DONE  = 3'd3;
   localparam state_t ST_CLEAR = 3'd4;

   typedef logic [1:0] prec_t;

   localparam prec_t PREC_8B     = 2'b00;
   localparam prec_t PREC_4B     = 2'b01;
   localparam prec_t PREC_2B     = 2'b10;
   localparam prec_t PREC_4B_ALT = 2'b11;

   // Number of serial cycles needed to consume one operand pair.
   function automatic logic [3:0] period_from_prec(input prec_t prec);
      logic [3:0] period;
      case (prec)
         PREC_8B:     period = 4'd8;
         PREC_4B:     period = 4'd4;
         PREC_2B:     period = 4'd2;
         PREC_4B_ALT: period = 4'd4;
         default:     period = 4'd4;
      endcase
      return period;
   endfunction

endpackage

// File: rtl/bsn_mac_sequencer_if.sv
// Bundle of control, operand, MAC-drive and result signals around the sequencer.
// slave = sequencer side, master = host/MAC side.
interface bsn_mac_sequencer_if #(parameter int VEC_W = 8) ();

   logic             start;
   logic [1:0]       prec;
   logic [VEC_W-1:0] vec_len;
   logic             busy;
   logic             op_valid;
   logic             op_ready;
   logic [7:0]       op_act;
   logic [7:0]       op_wgt;
   logic             mac_en;
   logic             mac_clr_n;
   logic [1:0]       mac_prec;
   logic [7:0]       mac_act;
   logic [7:0]       mac_wgt;
   logic [19:0]      mac_result;
   logic             res_valid;
   logic             res_ready;
   logic [19:0]      res_data;

   modport master (
      output start, prec, vec_len, op_valid, op_act, op_wgt, mac_result, res_ready,
      input  busy, op_ready, mac_en, mac_clr_n, mac_prec, mac_act, mac_wgt,
             res_valid, res_data
   );

   modport slave (
      input  start, prec, vec_len, op_valid, op_act, op_wgt, mac_result, res_ready,
      output busy, op_ready, mac_en, mac_clr_n, mac_prec, mac_act, mac_wgt,
             res_valid, res_data
   );

endinterface

// File: rtl/bsn_mac_sequencer_period_counter.sv
// Bit-position counter for one serial period: advances when enabled and wraps
// at period-1; boundary marks position 0 where a new pair may start.
module bsn_period_counter (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [3:0] period,
   output logic       boundary
);

   logic [2:0] cnt_q;
   logic [2:0] cnt_d;
   logic [2:0] last_cnt;

   // Next bit position.
   always_comb begin
      last_cnt = 3'(period - 4'd1);
      if (!en) begin
         cnt_d = cnt_q;
      end else if (cnt_q == last_cnt) begin
         cnt_d = 3'd0;
      end else begin
         cnt_d = cnt_q + 3'd1;
      end
   end

   // Bit position register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign boundary = (cnt_q == 3'd0);

endmodule

// File: rtl/bsn_mac_sequencer.sv
// Dot-product sequencer feeding a bit-serial MAC one operand pair per period.
// Optional busy-cycle counter on perf_cycles when BSN_SEQ_PERF_CNT_EN is defined.
module bsn_mac_sequencer
   import bsn_pkg::*;
#(
   parameter int VEC_W = 8
) (
   input logic clk,
   input logic rstn,
   bsn_mac_sequencer_if.slave bus
`ifdef BSN_SEQ_PERF_CNT_EN
   ,
   output logic [15:0] perf_cycles
`endif
);

   state_t         state_q, state_d;
   prec_t          prec_q, prec_d;
   logic [VEC_W:0] len_q, len_d;
   logic [VEC_W:0] pairs_q, pairs_d;
   logic [7:0]     act_q, act_d;
   logic [7:0]     wgt_q, wgt_d;
   logic           mac_en_q;
   logic           clr_n_q, clr_n_d;
   logic           res_valid_q, res_valid_d;
   logic [19:0]    res_data_q, res_data_d;
   logic           cnt_en;
   logic           boundary;
   logic           op_ready_s;
   logic           accept;
   logic [3:0]     period;

   assign period     = period_from_prec(prec_q);
   assign op_ready_s = (state_q == ST_RUN) && boundary && (pairs_q < len_q);
   assign accept     = op_ready_s && bus.op_valid;

   bsn_period_counter u_period (
      .clk      (clk),
      .rstn     (rstn),
      .en       (cnt_en),
      .period   (period),
      .boundary (boundary)
   );

   // Sequencer next-state; cnt_en doubles as next-cycle mac_en.
   always_comb begin
      state_d     = state_q;
      prec_d      = prec_q;
      len_d       = len_q;
      pairs_d     = pairs_q;
      act_d       = act_q;
      wgt_d       = wgt_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      cnt_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               prec_d  = bus.prec;
               len_d   = {1'b0, bus.vec_len};
               pairs_d = {(VEC_W+1){1'b0}};
               if (bus.vec_len == {VEC_W{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept) begin
               act_d   = bus.op_act;
               wgt_d   = bus.op_wgt;
               pairs_d = pairs_q + {{VEC_W{1'b0}}, 1'b1};
               cnt_en  = 1'b1;
            end else if (boundary && (pairs_q == len_q)) begin
               // Last period just finished: push zeros to drain the MAC.
               state_d = ST_FLUSH;
               act_d   = 8'd0;
               wgt_d   = 8'd0;
               cnt_en  = 1'b1;
            end else begin
               cnt_en = !boundary;
            end
         end
         ST_FLUSH: begin
            if (boundary) begin
               state_d = ST_DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_DONE: begin
            if (!res_valid_q) begin
               res_valid_d = 1'b1;
               res_data_d  = (len_q == {(VEC_W+1){1'b0}}) ? 20'd0 : bus.mac_result;
            end else if (bus.res_ready) begin
               res_valid_d = 1'b0;
               res_data_d  = 20'd0;
               state_d     = ST_CLEAR;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_CLEAR: begin
            state_d = ST_IDLE;
            prec_d  = PREC_8B;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      clr_n_d = (state_d != ST_CLEAR);
   end

   // Sequencer state and registered MAC/result drive.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         prec_q      <= PREC_8B;
         len_q       <= {(VEC_W+1){1'b0}};
         pairs_q     <= {(VEC_W+1){1'b0}};
         act_q       <= 8'd0;
         wgt_q       <= 8'd0;
         mac_en_q    <= 1'b0;
         clr_n_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 20'd0;
      end else begin
         state_q     <= state_d;
         prec_q      <= prec_d;
         len_q       <= len_d;
         pairs_q     <= pairs_d;
         act_q       <= act_d;
         wgt_q       <= wgt_d;
         mac_en_q    <= cnt_en;
         clr_n_q     <= clr_n_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.op_ready  = op_ready_s;
   assign bus.mac_en    = mac_en_q;
   assign bus.mac_clr_n = clr_n_q;
   assign bus.mac_prec  = prec_q;
   assign bus.mac_act   = act_q;
   assign bus.mac_wgt   = wgt_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;

`ifdef BSN_SEQ_PERF_CNT_EN
   logic [15:0] run_q, run_d;
   logic [15:0] perf_q, perf_d;

   // Saturating busy-cycle count, published when the result is reached.
   always_comb begin
      if (state_q == ST_IDLE) begin
         run_d = 16'd0;
      end else if (run_q != 16'hFFFF) begin
         run_d = run_q + 16'd1;
      end else begin
         run_d = run_q;
      end
      if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
         perf_d = run_d;
      end else begin
         perf_d = perf_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_q  <= 16'd0;
         perf_q <= 16'd0;
      end else begin
         run_q  <= run_d;
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_bsn_mac_sequencer.sv
// Directed self-checking bench for bsn_mac_sequencer with a behavioural
// bit-serial MAC that adds act*wgt at the last bit position of each period.
module tb_bsn_mac_sequencer;

   logic clk;
   logic rstn;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   en_total = 0;
   int   t0;
   int   en0;
   int   lat;
   int   en_snap;

   bsn_mac_sequencer_if #(.VEC_W(8)) bus ();

`ifdef BSN_SEQ_PERF_CNT_EN
   logic [15:0] perf_cycles;
`endif

   bsn_mac_sequencer #(.VEC_W(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
`ifdef BSN_SEQ_PERF_CNT_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bus.mac_en) en_total <= en_total + 1;

   // Reference MAC
   logic signed [19:0] acc;
   logic [2:0]         ph;
   logic [2:0]         last_ph;
   logic signed [15:0] prod;

   assign prod = $signed(bus.mac_act) * $signed(bus.mac_wgt);

   always_comb begin
      case (bus.mac_prec)
         2'b00:   last_ph = 3'd7;
         2'b10:   last_ph = 3'd1;
         default: last_ph = 3'd3;
      endcase
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc <= 20'sd0;
         ph  <= 3'd0;
      end else if (!bus.mac_clr_n) begin
         acc <= 20'sd0;
         ph  <= 3'd0;
      end else if (bus.mac_en) begin
         if (ph == last_ph) begin
            acc <= acc + {{4{prod[15]}}, prod};
            ph  <= 3'd0;
         end else begin
            ph <= ph + 3'd1;
         end
      end
   end

   assign bus.mac_result = acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [1:0] p, input logic [7:0] k);
      bus.start   = 1'b1;
      bus.prec    = p;
      bus.vec_len = k;
      @(posedge clk);
      #1;
      t0 = cyc;
      en0 = en_total;
      bus.start = 1'b0;
   endtask

   task automatic send_pair(input logic [7:0] a, input logic [7:0] w);
      logic done;
      done = 1'b0;
      bus.op_valid = 1'b1;
      bus.op_act   = a;
      bus.op_wgt   = w;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.op_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
            break;
         end
      end
      bus.op_valid = 1'b0;
      chk("pair_accepted", 32'(done), 32'd1);
   endtask

   task automatic wait_result(output int latency);
      logic found;
      found = 1'b0;
      latency = -1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (bus.res_valid) begin
            found = 1'b1;
            latency = cyc - t0;
            break;
         end
      end
      chk("result_seen", 32'(found), 32'd1);
   endtask

   task automatic release_result();
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      chk("clear_clr_n_low", 32'(bus.mac_clr_n), 32'd0);
      chk("clear_busy", 32'(bus.busy), 32'd1);
      chk("clear_valid_drop", 32'(bus.res_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("idle_clr_n_high", 32'(bus.mac_clr_n), 32'd1);
      chk("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_op_ready"}, 32'(bus.op_ready), 32'd0);
      chk({tag, "_mac_en"}, 32'(bus.mac_en), 32'd0);
      chk({tag, "_mac_clr_n"}, 32'(bus.mac_clr_n), 32'd0);
      chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      chk({tag, "_res_data"}, 32'(bus.res_data), 32'd0);
      chk({tag, "_mac_act"}, 32'(bus.mac_act), 32'd0);
      chk({tag, "_mac_wgt"}, 32'(bus.mac_wgt), 32'd0);
      chk({tag, "_mac_prec"}, 32'(bus.mac_prec), 32'd0);
   endtask

   initial begin
      rstn          = 1'b0;
      bus.start     = 1'b0;
      bus.prec      = 2'b00;
      bus.vec_len   = 8'd0;
      bus.op_valid  = 1'b0;
      bus.op_act    = 8'd0;
      bus.op_wgt    = 8'd0;
      bus.res_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rstn = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("post_reset_clr_n", 32'(bus.mac_clr_n), 32'd1);
      chk("post_reset_busy", 32'(bus.busy), 32'd0);

      // 8-bit, K=2: 3*2 + 5*(-1) = 1, latency 1+3*8+1 = 26
      do_start(2'b00, 8'd2);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      chk("t1_prec", 32'(bus.mac_prec), 32'd0);
      send_pair(8'd3, 8'd2);
      send_pair(8'd5, 8'hFF);
      wait_result(lat);
      chk("t1_latency", 32'(lat), 32'd26);
      chk("t1_res_data", 32'(bus.res_data), 32'h00001);
      chk("t1_mac_en_cycles", 32'(en_total - en0), 32'd24);
      release_result();

      // 2-bit, K=3: three 1*1 pairs = 3, latency 1+4*2+1 = 10
      do_start(2'b10, 8'd3);
      chk("t2_prec", 32'(bus.mac_prec), 32'd2);
      send_pair(8'd1, 8'd1);
      send_pair(8'd1, 8'd1);
      send_pair(8'd1, 8'd1);
      wait_result(lat);
      chk("t2_latency", 32'(lat), 32'd10);
      chk("t2_res_data", 32'(bus.res_data), 32'h00003);
      chk("t2_mac_en_cycles", 32'(en_total - en0), 32'd8);
      release_result();

      // 8-bit, K=1, 5-cycle stall at the boundary: 7*(-3) = -21, latency 18+5
      do_start(2'b00, 8'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("t3_ready_after_stall", 32'(bus.op_ready), 32'd1);
      chk("t3_no_mac_en_in_stall", 32'(en_total - en0), 32'd0);
      send_pair(8'd7, 8'hFD);
      wait_result(lat);
      chk("t3_latency", 32'(lat), 32'd23);
      chk("t3_res_data", 32'(bus.res_data), 32'hFFFEB);
      chk("t3_mac_en_cycles", 32'(en_total - en0), 32'd16);
      release_result();

      // K=0: immediate zero result, no mac_en pulse
      do_start(2'b01, 8'd0);
      chk("t4_op_ready", 32'(bus.op_ready), 32'd0);
      wait_result(lat);
      chk("t4_res_data", 32'(bus.res_data), 32'd0);
      chk("t4_mac_en_cycles", 32'(en_total - en0), 32'd0);
      release_result();

      // Reset in the 4th FLUSH cycle of an 8-bit K=1 run
      do_start(2'b00, 8'd1);
      send_pair(8'd2, 8'd2);
      repeat (11) @(posedge clk);
      #1;
      chk("t5_in_flush_mac_en", 32'(bus.mac_en), 32'd1);
      chk("t5_in_flush_act", 32'(bus.mac_act), 32'd0);
      rstn = 1'b0;
      #1;
      chk_all_zero("t5_abort");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_idle_after_release", 32'(bus.busy), 32'd0);
      chk("t5_no_result", 32'(bus.res_valid), 32'd0);

      // 4-bit, K=2 after abort: 2*3 + (-4)*1 = 2, latency 1+3*4+1 = 14
      do_start(2'b01, 8'd2);
      send_pair(8'd2, 8'd3);
      send_pair(8'hFC, 8'd1);
      wait_result(lat);
      chk("t6_latency", 32'(lat), 32'd14);
      chk("t6_res_data", 32'(bus.res_data), 32'h00002);

      // Hold off res_ready for 10 cycles while pulsing start
      en_snap = en_total;
      for (int i = 0; i < 10; i++) begin
         bus.start   = ((i % 2) == 0);
         bus.prec    = 2'b10;
         bus.vec_len = 8'd5;
         @(posedge clk);
         #1;
         chk("t6_hold", {11'd0, bus.res_valid, bus.res_data}, {11'd0, 1'b1, 20'h00002});
      end
      bus.start = 1'b0;
      chk("t6_hold_no_mac_en", 32'(en_total - en_snap), 32'd0);
      chk("t6_hold_prec", 32'(bus.mac_prec), 32'd1);
      release_result();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bsn_mac_sequencer.md
BSN_MAC_SEQUENCER -- requirements
Module: bsn_mac_sequencer

Interface
REQ-001 SHALL have parameter VEC_W, default 8: width of vec_len.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: begin dot product; sampled only in IDLE.
REQ-005 SHALL have port prec, input, 2: precision (00=8b, 01=4b, 10=2b, 11=4b); sampled with start.
REQ-006 SHALL have port vec_len, input, VEC_W: pair count K; sampled with start.
REQ-007 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-008 SHALL have port op_valid / op_ready, input / output, 1 each: operand-pair handshake.
REQ-009 SHALL have ports op_act and op_wgt, inputs, 8 each: signed activation and weight.
REQ-010 SHALL have ports mac_en, mac_clr_n, mac_prec, mac_act, mac_wgt, outputs, 1/1/2/8/8: bit-serial MAC drive.
REQ-011 SHALL have port mac_result, input, 20: MAC accumulator value.
REQ-012 SHALL have ports res_valid / res_ready / res_data, out / in / out, 1/1/20: result handshake.

Function
REQ-013 Period P SHALL be 8, 4, 2 or 4 for prec 00, 01, 10 or 11; mac_prec SHALL hold the captured prec until return to IDLE.
REQ-014 States SHALL be IDLE, RUN, FLUSH, DONE and CLEAR.
REQ-015 IDLE + start with K>0 -> RUN; IDLE + start with K=0 -> DONE with res_data=0 and no mac_en cycle.
REQ-016 In RUN, op_ready SHALL be high only at a period boundary, where the bit counter is 0.
REQ-017 Pair accepted (op_valid&op_ready) -> registered into mac_act/mac_wgt; mac_en=1 for exactly P consecutive cycles starting the next cycle.
REQ-018 If no pair is offered at a boundary, mac_en SHALL be 0 (stall); operands and bit counter SHALL hold, and there is no timeout.
REQ-019 After the K-th period, RUN -> FLUSH; FLUSH drives mac_act=mac_wgt=0 with mac_en=1 for P cycles.
REQ-020 FLUSH end -> DONE; on the following edge res_data <= mac_result and res_valid=1.
REQ-021 res_data and res_valid SHALL hold until res_ready; on that handshake -> CLEAR.
REQ-022 CLEAR SHALL drive a registered mac_clr_n=0 for exactly one cycle, then go to IDLE.
REQ-023 start SHALL be ignored while busy; op_ready SHALL be 0 outside RUN.
REQ-024 The pair counter SHALL be VEC_W+1 bits so that K=2^VEC_W-1 does not wrap.
REQ-025 Latency from start to res_valid, with no stalls, SHALL be 1+(K+1)*P+1 cycles.

Reset
REQ-026 rstn low SHALL put the block in IDLE and zero all counters.
REQ-027 While rstn is low: mac_clr_n=0, and busy, op_ready, mac_en, res_valid, res_data, mac_act, mac_wgt and mac_prec SHALL all be 0.
REQ-028 Reset mid-operation SHALL abort; no result is produced and the first cycle after release is IDLE.

Configuration
REQ-029 With BSN_SEQ_PERF_CNT_EN defined: output perf_cycles[15:0] counts busy cycles of the last completed operation, saturates at 0xFFFF, and updates on entry to DONE.
REQ-030 Without BSN_SEQ_PERF_CNT_EN: the perf_cycles port and its counter are absent; all other behaviour is identical.

Structure
REQ-031 Package bsn_pkg SHALL hold the state enum, the prec encodings, and a period-from-prec function.
REQ-032 Sub-module bsn_period_counter SHALL be the 3-bit bit counter with enable and wrap at P-1, and SHALL provide a boundary flag.

Verification
REQ-033 prec=00, K=2, pairs (3,2) then (5,-1), no stalls -> res_data=1, res_valid 26 cycles after start.
REQ-034 prec=10, K=3, pairs (1,1) x3 -> res_data=3, latency 10; mac_en high for exactly 8 cycles.
REQ-035 prec=00, K=1, op_valid held low 5 cycles at the boundary -> mac_en=0 for those 5 cycles, and result equals the no-stall case with latency +5.
REQ-036 K=0 -> res_valid with res_data=0, no mac_en pulse; res_ready -> one mac_clr_n low cycle, then busy=0.
REQ-037 rstn asserted in cycle 4 of FLUSH -> all outputs 0 immediately; next start runs normally.
REQ-038 res_ready held low 10 cycles -> res_data stable; start pulses during that time are ignored.
